// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams.
// A granted requester keeps the transmitter until its last byte or a HOLD_MAX idle timeout.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ack,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     grant_vld
);
  localparam int IDW = $clog2(NREQ);
  localparam int HCW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr, r_gid;
  logic [HCW-1:0]  r_hold;
  logic            r_last, r_start, r_vld;
  logic [NREQ-1:0] r_ack;
  logic [7:0]      r_data;

  logic [IDW-1:0]  w_win, w_sel_id, w_ptr_nxt;
  logic            w_any, w_own_req, w_launch, w_release, w_sel_last;
  logic [7:0]      w_sel_data;
  logic [NREQ-1:0] w_sel_oh;
  logic [HCW-1:0]  w_hold_nxt;
  int              w_idx;

  // Reverse scan so the candidate closest to r_ptr is assigned last and wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (req[IDW'(w_idx)]) begin
        w_win = IDW'(w_idx);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_id   = (r_state == S_IDLE) ? w_win : r_gid;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_sel_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_sel_id) begin
        w_sel_data  = req_data[8*i +: 8];
        w_sel_last  = req_last[i];
        w_sel_oh[i] = 1'b1;
      end
    end
    w_own_req  = req[r_gid] && !tx_busy;
    w_ptr_nxt  = (int'(r_gid) == NREQ - 1) ? '0 : r_gid + 1'b1;
    w_hold_nxt = (r_hold == HCW'(HOLD_MAX)) ? r_hold : r_hold + 1'b1;
    w_launch   = ((r_state == S_IDLE) && w_any && !tx_busy) ||
                 ((r_state == S_WAIT) && tx_done && !r_last && w_own_req) ||
                 ((r_state == S_HOLD) && w_own_req);
    w_release  = ((r_state == S_WAIT) && tx_done && r_last) ||
                 ((r_state == S_HOLD) && !w_own_req && (w_hold_nxt == HCW'(HOLD_MAX)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_hold  <= '0;
      r_last  <= 1'b0;
      r_start <= 1'b0;
      r_vld   <= 1'b0;
      r_ack   <= '0;
      r_data  <= 8'h00;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      if (w_launch) begin
        r_state <= S_START;
        r_gid   <= w_sel_id;
        r_vld   <= 1'b1;
        r_data  <= w_sel_data;
        r_last  <= w_sel_last;
        r_ack   <= w_sel_oh;
        r_start <= 1'b1;
        r_hold  <= '0;
      end else if (w_release) begin
        r_state <= S_IDLE;
        r_ptr   <= w_ptr_nxt;
        r_vld   <= 1'b0;
        r_hold  <= '0;
      end else begin
        case (r_state)
          S_START: r_state <= S_WAIT;
          S_WAIT: if (tx_done) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
          end
          S_HOLD:  r_hold <= w_hold_nxt;
          default: ;
        endcase
      end
    end
  end

  assign req_ack   = r_ack;
  assign tx_start  = r_start;
  assign tx_data   = r_data;
  assign grant_id  = r_gid;
  assign grant_vld = r_vld;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/transmitter models drive the DUT,
// a frame-level round-robin model predicts (owner, byte) for every tx_start.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int HOLD_MAX = 4;

  typedef struct {logic [7:0] d; logic last; int gap;} rbyte_t;
  typedef struct {int id; logic [7:0] d;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ-1:0] req = '0, req_last = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic m_busy = 1'b0, f_busy = 1'b0, tx_done = 1'b0;
  logic tx_busy;
  logic [NREQ-1:0] req_ack;
  logic tx_start, grant_vld;
  logic [7:0] tx_data;
  logic [1:0] grant_id;

  rbyte_t rq[NREQ][$];
  exp_t   expq[$];
  int gapc[NREQ];
  int tx_cnt = 0, tx_len = 0, mptr = 0;
  int errors = 0, checks = 0;

  assign tx_busy = m_busy | f_busy;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_id(grant_id), .grant_vld(grant_vld));

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void push_byte(int id, logic [7:0] d, logic last, int gap);
    rq[id].push_back('{d, last, gap});
  endfunction

  // Frame-level reference: whole frames go out one at a time, next owner is the
  // first requester with queued frames at or after the pointer.
  function automatic void plan();
    rbyte_t c[NREQ][$];
    rbyte_t b;
    int id;
    for (int i = 0; i < NREQ; i++) c[i] = rq[i];
    while (1) begin
      id = -1;
      for (int k = 0; k < NREQ && id < 0; k++)
        if (c[(mptr + k) % NREQ].size() > 0) id = (mptr + k) % NREQ;
      if (id < 0) break;
      do begin
        b = c[id].pop_front();
        expq.push_back('{id, b.d});
      end while (!b.last && c[id].size() > 0);
      mptr = (id + 1) % NREQ;
    end
  endfunction

  function automatic bit tb_idle();
    bit r;
    r = (tx_cnt == 0) && !tx_done && (expq.size() == 0) && !grant_vld;
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) r = 1'b0;
    return r;
  endfunction

  // One clock of the requester and transmitter models, updated on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (tx_done) tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin m_busy = 1'b0; tx_done = 1'b1; end
    end else if (tx_start && rst_n) begin
      m_busy = 1'b1;
      tx_cnt = (tx_len > 0) ? tx_len : int'($urandom_range(1, 6));
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] && rq[i].size() > 0) begin
        void'(rq[i].pop_front());
        gapc[i] = 0;
      end
      req[i] = 1'b0;
      if (rq[i].size() > 0) begin
        if (gapc[i] < rq[i][0].gap) gapc[i]++;
        else begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0].d;
          req_last[i] = rq[i][0].last;
        end
      end
    end
  endtask

  task automatic clear_tb();
    for (int i = 0; i < NREQ; i++) begin rq[i].delete(); gapc[i] = 0; end
    expq.delete();
    req = '0;
    mptr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_sig(string nm, bit on_done);
    int n;
    n = 0;
    while (n < 200 && !(on_done ? tx_done : tx_start)) begin tick(); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: timed out after %0d cycles", nm, n);
    end
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (n < 3000 && !tb_idle()) begin tick(); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s: not drained, %0d bytes still expected", nm, expq.size());
    end
  endtask

  // Scoreboard monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got id=%0d data=%h, expected no start", grant_id, tx_data);
          end else begin
            e = expq.pop_front();
            if (int'(grant_id) != e.id || tx_data != e.d || !grant_vld ||
                req_ack != (4'b0001 << e.id)) begin
              errors++;
              $display("FAIL sb_byte: got id=%0d data=%h ack=%b vld=%b expected id=%0d data=%h",
                       grant_id, tx_data, req_ack, grant_vld, e.id, e.d);
            end
          end
        end else if (req_ack != '0) begin
          checks++; errors++;
          $display("FAIL sb_ack_no_start: got ack=%b expected 0000", req_ack);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nf, len;
    for (int i = 0; i < NREQ; i++) gapc[i] = 0;
    tick(); tick();
    chk("rst_ack", int'(req_ack), 0);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_vld", int'(grant_vld), 0);
    rst_n = 1'b1;

    // Single byte, one-clock latency, release after tx_done
    do_reset();
    tx_len = 3;
    push_byte(0, 8'hA5, 1'b1, 0); plan();
    tick();
    tick();
    chk("lat_start", int'(tx_start), 1);
    chk("lat_ack", int'(req_ack), 1);
    wait_sig("single_done", 1'b1);
    chk("vld_at_done", int'(grant_vld), 1);
    tick();
    chk("vld_released", int'(grant_vld), 0);
    drain("single");

    // Round robin over 8 single-byte frames
    do_reset();
    tx_len = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NREQ; i++) push_byte(i, 8'(16 * i + f), 1'b1, 0);
    plan(); tick(); drain("round_robin");

    // Frame lock: 11,22,33 contiguous before requester 2
    do_reset();
    push_byte(1, 8'h11, 1'b0, 0); push_byte(1, 8'h22, 1'b0, 0);
    push_byte(1, 8'h33, 1'b1, 0); push_byte(2, 8'h44, 1'b1, 0);
    plan(); tick(); drain("frame_lock");

    // Short gap inside a frame: lock kept through HOLD
    do_reset();
    tx_len = 1;
    push_byte(3, 8'hC1, 1'b0, 0); push_byte(3, 8'hC2, 1'b1, 2);
    expq.push_back('{3, 8'hC1}); expq.push_back('{3, 8'hC2}); expq.push_back('{1, 8'hD1});
    tick();
    wait_sig("hold_start", 1'b0);
    push_byte(1, 8'hD1, 1'b1, 0);
    drain("hold_keep");

    // Hold timeout: requester 3 stalls mid-frame, released HOLD_MAX cycles after tx_done
    do_reset();
    push_byte(3, 8'h5A, 1'b0, 0); push_byte(3, 8'h6B, 1'b1, 20);
    expq.push_back('{3, 8'h5A}); expq.push_back('{0, 8'h77}); expq.push_back('{3, 8'h6B});
    tick();
    wait_sig("to_start", 1'b0);
    push_byte(0, 8'h77, 1'b1, 0);
    wait_sig("to_done", 1'b1);
    repeat (4) tick();
    chk("to_vld_held", int'(grant_vld), 1);
    chk("to_gid_held", int'(grant_id), 3);
    tick();
    chk("to_vld_released", int'(grant_vld), 0);
    drain("hold_timeout");

    // Busy gating
    do_reset();
    tx_len = 2;
    f_busy = 1'b1;
    push_byte(0, 8'h3C, 1'b1, 0); plan();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("busy_no_start", int'(tx_start), 0);
    end
    f_busy = 1'b0;
    tick();
    chk("busy_start_next", int'(tx_start), 1);
    drain("busy_gate");

    // Reset mid-frame
    do_reset();
    tx_len = 12;
    push_byte(3, 8'h96, 1'b1, 0); plan();
    tick();
    wait_sig("mid_start", 1'b0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", int'(req_ack), 0);
    chk("mid_rst_start", int'(tx_start), 0);
    chk("mid_rst_data", int'(tx_data), 0);
    chk("mid_rst_gid", int'(grant_id), 0);
    chk("mid_rst_vld", int'(grant_vld), 0);
    clear_tb();
    tick();
    rst_n = 1'b1;
    tx_len = 0;
    push_byte(1, 8'hB1, 1'b1, 0); push_byte(3, 8'hB3, 1'b1, 0);
    plan(); tick(); drain("after_reset");

    // Randomized phases of simultaneous multi-frame traffic
    do_reset();
    for (int p = 0; p < 25; p++) begin
      repeat ($urandom_range(0, 4)) tick();
      for (int i = 0; i < NREQ; i++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) push_byte(i, 8'($urandom), (b == len - 1), 0);
        end
      end
      plan(); tick(); drain("random_phase");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter: HOLD_MAX, 255, max idle cycles a locked requester may keep the grant between bytes of a frame.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester byte-valid, level.
REQ-006 req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i].
REQ-007 req_last  input  NREQ  byte of requester i is last of its frame.
REQ-008 req_ack  output  NREQ  one-cycle pulse: byte of requester i consumed.
REQ-009 tx_start  output  1  one-cycle start strobe to transmitter.
REQ-010 tx_data  output  8  byte to transmitter, valid while tx_start high.
REQ-011 tx_busy  input  1  transmitter shifting a frame.
REQ-012 tx_done  input  1  one-cycle pulse at end of stop bit.
REQ-013 grant_id  output  $clog2(NREQ)  index of current owner; valid while grant_vld high.
REQ-014 grant_vld  output  1  a requester owns the transmitter.

Function
REQ-015 FSM states IDLE, START, WAIT, HOLD; encoding free.
REQ-016 IDLE: when any req bit is high and tx_busy is low, select the first requester with req high searching from ptr upward, modulo NREQ; go to START next cycle.
REQ-017 On entry to START: latch req_data and req_last of the winner, set grant_id and grant_vld, and drive req_ack[winner]=1 and tx_start=1 for exactly that one START cycle.
REQ-018 START -> WAIT unconditionally after one cycle; latency from req rising (arbiter in IDLE, tx_busy low) to tx_start is exactly 1 clock.
REQ-019 WAIT: hold until tx_done=1; tx_data stays at the latched byte throughout.
REQ-020 WAIT on tx_done with latched last=1: set ptr=(grant_id+1) mod NREQ, clear grant_vld, go to IDLE.
REQ-021 WAIT on tx_done with latched last=0: if req[grant_id]=1 go to START for the same requester (no re-arbitration), else go to HOLD.
REQ-022 HOLD: hold_cnt increments each cycle; req[grant_id]=1 -> START for the same requester and clear hold_cnt; hold_cnt reaching HOLD_MAX -> release exactly as REQ-020.
REQ-023 Other requesters are never granted while grant_vld=1 (frame lock).
REQ-024 At most one req_ack bit is high in any cycle; req_ack never high outside START.
REQ-025 tx_start never asserts while tx_busy=1; if tx_busy is high in IDLE, arbitration waits.
REQ-026 tx_done outside WAIT/HOLD is ignored.
REQ-027 A requester dropping req after ack and before tx_done has no effect on the byte in flight.
REQ-028 ptr wraps from NREQ-1 to 0; a single active requester is re-granted back-to-back frames.
REQ-029 hold_cnt width is $clog2(HOLD_MAX+1) and it saturates.

Reset
REQ-030 rst low asynchronously forces: state IDLE, ptr=0, hold_cnt=0, req_ack=0, tx_start=0, tx_data=8'h00, grant_id=0, grant_vld=0.
REQ-031 rst asserted mid-frame abandons the frame; after release, the first grant goes to the lowest-index active requester.
REQ-032 Outputs are driven from registers only; no combinational path from inputs to outputs.

Verification
REQ-033 Single byte: req[0]=1, req_data=8'hA5, last=1 -> tx_start with tx_data=8'hA5 one clock later, req_ack[0] in the same cycle, grant_vld released the cycle after tx_done.
REQ-034 Round robin: req=4'b1111 all last=1 for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-035 Frame lock: req[1] sends 3 bytes 11,22,33 (last on 33) while req[2] is high -> bytes 11,22,33 go out contiguously, then requester 2 is granted.
REQ-036 Hold timeout: req[3] sends last=0 then drops req, HOLD_MAX=4 -> grant released 4 cycles after tx_done, and the next requester is granted.
REQ-037 Busy gating: tx_busy=1 held while req=4'b0001 -> no tx_start until tx_busy falls, then tx_start on the next clock.
REQ-038 Reset mid-frame: rst low during WAIT -> all outputs zero immediately; after release, req=4'b1010 -> requester 1 is granted first.
